// File: rtl/breakout_pkg.sv
// Shared breakout definitions: brick-field geometry, the block_map FSM
// encoding and a small popcount helper.
package breakout_pkg;

  localparam int BORDER_WIDTH   = 8;
  localparam int BLOCK_WIDTH    = 48;
  localparam int BLOCK_HEIGHT   = 16;
  localparam int BLOCKS_PER_ROW = 13;
  localparam int NUM_ROWS       = 16;
  localparam int NUM_BLOCKS     = BLOCKS_PER_ROW * NUM_ROWS;
  localparam int HEIGHT_SHIFT   = $clog2(BLOCK_HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    UPD  = 2'd3
  } state_t;

  function automatic logic [3:0] popcount13(input logic [12:0] bits);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 13; i++) cnt = cnt + {3'd0, bits[i]};
    return cnt;
  endfunction

endpackage

// File: rtl/level_row_pattern.sv
// Layout table: the brick bits for one row of the selected level.
// New levels are added here without touching the block_map FSM.
module level_row_pattern
  import breakout_pkg::*;
(
  input  logic [1:0]                level,
  input  logic [3:0]                row,
  output logic [BLOCKS_PER_ROW-1:0] row_bits
);

  always_comb begin
    row_bits = '0;
    case (level)
      2'd0: if (row >= 4'd2 && row <= 4'd9) row_bits = '1;
      // Checkerboard: a brick wherever row+col is even.
      2'd1: if (row >= 4'd2 && row <= 4'd11) row_bits = row[0] ? 13'h0AAA : 13'h1555;
      2'd3: if (row >= 4'd4 && row <= 4'd11) row_bits = 13'h0FFE;
      default: row_bits = '1;
    endcase
  end

endmodule

// File: rtl/block_map.sv
// Brick map owner: loads level layouts row by row and services brick-hit
// requests (pixel -> brick index by repeated subtraction), clearing bricks.
module block_map
  import breakout_pkg::*;
(
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  load_level,
  input  logic [1:0]            level,
  input  logic                  hit_req,
  input  logic [9:0]            hit_x,
  input  logic [8:0]            hit_y,
  output logic                  hit_ack,
  output logic                  hit_valid,
  output logic [NUM_BLOCKS-1:0] block_state,
  output logic [7:0]            blocks_left,
  output logic                  busy,
  output logic                  level_clear
);

  // Handshake: hit_req rises and holds hit_x/hit_y stable until hit_ack
  // pulses for one cycle; hit_valid is only meaningful alongside hit_ack,
  // and a hit_req still high in the ack cycle is not accepted again.

  localparam logic [9:0] X_MIN  = 10'(BORDER_WIDTH);
  localparam logic [9:0] X_END  = 10'(BORDER_WIDTH + BLOCK_WIDTH * BLOCKS_PER_ROW);
  localparam logic [8:0] Y_MIN  = 9'(BORDER_WIDTH);
  localparam logic [8:0] Y_END  = 9'(BORDER_WIDTH + BLOCK_HEIGHT * NUM_ROWS);
  localparam logic [9:0] BW     = 10'(BLOCK_WIDTH);
  localparam logic [9:0] BW2    = 10'(2 * BLOCK_WIDTH);
  localparam logic [7:0] ROW_W  = 8'(BLOCKS_PER_ROW);

  state_t      state, next_state;
  logic [1:0]  level_q;
  logic [3:0]  load_row, hit_row, hit_col;
  logic [9:0]  rem;
  logic        invalid;
  logic [12:0] row_bits;

  logic [9:0]  x_off;
  logic [8:0]  y_off;
  logic        out_of_field, hit_accept, upd_valid;
  logic [7:0]  idx, load_base;
  logic        ack_d, valid_d, clear_d, busy_d;

  level_row_pattern u_pattern (
    .level    (level_q),
    .row      (load_row),
    .row_bits (row_bits)
  );

  always_comb begin
    x_off        = hit_x - X_MIN;
    y_off        = hit_y - Y_MIN;
    out_of_field = (hit_x < X_MIN) || (hit_x >= X_END) || (hit_y < Y_MIN) || (hit_y >= Y_END);
    hit_accept   = (state == IDLE) && hit_req && !hit_ack && !load_level;
    idx          = {4'd0, hit_row} * ROW_W + {4'd0, hit_col};
    load_base    = {4'd0, load_row} * ROW_W;
    upd_valid    = !invalid && block_state[idx];
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= next_state;
  end

  // A contact already in column 0 skips DIV, keeping the ack at col+2 edges.
  always_comb begin
    next_state = state;
    if (load_level) begin
      next_state = LOAD;
    end else begin
      case (state)
        IDLE: if (hit_accept) next_state = (out_of_field || x_off < BW) ? UPD : DIV;
        LOAD: if (load_row == 4'd15) next_state = IDLE;
        DIV:  if (rem < BW2) next_state = UPD;
        UPD:  next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    ack_d   = (state == UPD) && !load_level;
    valid_d = ack_d && upd_valid;
    clear_d = valid_d && (blocks_left == 8'd1);
    busy_d  = (next_state == LOAD);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      block_state <= '0;
      blocks_left <= '0;
      hit_ack     <= 1'b0;
      hit_valid   <= 1'b0;
      level_clear <= 1'b0;
      busy        <= 1'b0;
      level_q     <= '0;
      load_row    <= '0;
      hit_row     <= '0;
      hit_col     <= '0;
      rem         <= '0;
      invalid     <= 1'b0;
    end else begin
      hit_ack     <= ack_d;
      hit_valid   <= valid_d;
      level_clear <= clear_d;
      busy        <= busy_d;
      if (load_level) begin
        block_state <= '0;
        blocks_left <= '0;
        load_row    <= '0;
        level_q     <= level;
      end else begin
        case (state)
          IDLE: if (hit_accept) begin
            invalid <= out_of_field;
            hit_row <= 4'(y_off >> HEIGHT_SHIFT);
            rem     <= x_off;
            hit_col <= '0;
          end
          LOAD: begin
            block_state[load_base +: BLOCKS_PER_ROW] <= row_bits;
            blocks_left <= blocks_left + {4'd0, popcount13(row_bits)};
            load_row    <= load_row + 4'd1;
          end
          DIV: begin
            rem     <= rem - BW;
            hit_col <= hit_col + 4'd1;
          end
          UPD: if (upd_valid) begin
            block_state[idx] <= 1'b0;
            blocks_left      <= blocks_left - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_map.sv
// Directed bench for block_map: level loads, a table of hit vectors, a full
// level clear, reset during a load and a load that interrupts a hit.
module tb_block_map;

  logic         clk = 1'b0;
  logic         nRst = 1'b0;
  logic         load_level = 1'b0;
  logic [1:0]   level = '0;
  logic         hit_req = 1'b0;
  logic [9:0]   hit_x = '0;
  logic [8:0]   hit_y = '0;
  logic         hit_ack, hit_valid, busy, level_clear;
  logic [207:0] block_state;
  logic [7:0]   blocks_left;

  int checks = 0, errors = 0;
  int mon_checks = 0, mon_errors = 0, clear_cnt = 0;
  logic [207:0] exp_map;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    int         edges;
    logic       valid;
    int         idx;
    int         left;
  } hit_vec_t;

  hit_vec_t tbl[12];

  block_map dut (
    .clk         (clk),
    .nRst        (nRst),
    .load_level  (load_level),
    .level       (level),
    .hit_req     (hit_req),
    .hit_x       (hit_x),
    .hit_y       (hit_y),
    .hit_ack     (hit_ack),
    .hit_valid   (hit_valid),
    .block_state (block_state),
    .blocks_left (blocks_left),
    .busy        (busy),
    .level_clear (level_clear)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (level_clear === 1'b1) clear_cnt++;
    if (nRst) begin
      mon_checks++;
      if (hit_valid && !hit_ack) begin
        mon_errors++;
        $display("FAIL valid_without_ack: hit_valid=%0b hit_ack=%0b required hit_valid=0", hit_valid, hit_ack);
      end
    end
  end

  task automatic chk(input string name, input logic [207:0] act, input logic [207:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [207:0] layout_map(input int lvl);
    logic [207:0] m;
    logic         b;
    m = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 13; c++) begin
        case (lvl)
          0:       b = (r >= 2 && r <= 9);
          1:       b = (r >= 2 && r <= 11 && ((r + c) % 2 == 0));
          2:       b = 1'b1;
          default: b = (r >= 4 && r <= 11 && c >= 1 && c <= 11);
        endcase
        m[r*13+c] = b;
      end
    end
    return m;
  endfunction

  task automatic do_load(input int lvl, input int total);
    int n;
    @(negedge clk);
    load_level = 1'b1;
    level      = 2'(lvl);
    @(negedge clk);
    load_level = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    exp_map = layout_map(lvl);
    chk($sformatf("load%0d_busy_cycles", lvl), n, 16);
    chk($sformatf("load%0d_block_state", lvl), block_state, exp_map);
    chk($sformatf("load%0d_blocks_left", lvl), blocks_left, total);
  endtask

  // Returns the number of edges from the accept edge to the ack (40 = timed out).
  task automatic do_hit(input logic [9:0] x, input logic [8:0] y,
                        output int edges, output logic v, output logic lc);
    @(negedge clk);
    hit_req = 1'b1;
    hit_x   = x;
    hit_y   = y;
    edges   = 0;
    v       = 1'b0;
    lc      = 1'b0;
    while (edges < 40) begin
      @(negedge clk);
      edges++;
      if (hit_ack) break;
    end
    v       = hit_valid;
    lc      = level_clear;
    hit_req = 1'b0;
    @(negedge clk);
    chk("ack_single_cycle", {hit_ack, hit_valid, level_clear}, 3'b000);
  endtask

  initial begin
    int   edges, busy_n, idle_n, acks, base;
    logic v, lc;

    tbl[0]  = '{x: 600, y: 263, edges: 14, valid: 1'b1, idx: 207, left: 207};
    tbl[1]  = '{x: 600, y: 263, edges: 14, valid: 1'b0, idx: 0,   left: 207};
    tbl[2]  = '{x: 4,   y: 100, edges: 2,  valid: 1'b0, idx: 0,   left: 207};
    tbl[3]  = '{x: 300, y: 270, edges: 2,  valid: 1'b0, idx: 0,   left: 207};
    tbl[4]  = '{x: 8,   y: 8,   edges: 2,  valid: 1'b1, idx: 0,   left: 206};
    tbl[5]  = '{x: 55,  y: 8,   edges: 2,  valid: 1'b0, idx: 0,   left: 206};
    tbl[6]  = '{x: 56,  y: 8,   edges: 3,  valid: 1'b1, idx: 1,   left: 205};
    tbl[7]  = '{x: 631, y: 8,   edges: 14, valid: 1'b1, idx: 12,  left: 204};
    tbl[8]  = '{x: 632, y: 8,   edges: 2,  valid: 1'b0, idx: 0,   left: 204};
    tbl[9]  = '{x: 100, y: 7,   edges: 2,  valid: 1'b0, idx: 0,   left: 204};
    tbl[10] = '{x: 100, y: 264, edges: 2,  valid: 1'b0, idx: 0,   left: 204};
    tbl[11] = '{x: 300, y: 100, edges: 8,  valid: 1'b1, idx: 71,  left: 203};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {block_state, blocks_left, hit_ack, hit_valid, busy, level_clear}, '0);
    nRst = 1'b1;

    // Reset in the middle of a level-2 load, after five rows
    @(negedge clk);
    load_level = 1'b1;
    level      = 2'd2;
    @(negedge clk);
    load_level = 1'b0;
    repeat (5) @(negedge clk);
    chk("midload_partial_left", blocks_left, 65);
    #2 nRst = 1'b0;
    #1;
    chk("midload_reset_state", block_state, '0);
    chk("midload_reset_flags", {blocks_left, busy, hit_ack, hit_valid, level_clear}, '0);
    @(negedge clk);
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_reset_idle", {block_state, blocks_left, busy, hit_ack}, '0);

    // Each layout
    do_load(0, 104);
    do_load(1, 65);
    do_load(3, 88);
    do_load(2, 208);

    // Hit vectors against level 2
    for (int i = 0; i < 12; i++) begin
      do_hit(tbl[i].x, tbl[i].y, edges, v, lc);
      if (tbl[i].valid) exp_map[tbl[i].idx] = 1'b0;
      chk($sformatf("vec%0d_latency", i), edges, tbl[i].edges);
      chk($sformatf("vec%0d_hit_valid", i), v, tbl[i].valid);
      chk($sformatf("vec%0d_blocks_left", i), blocks_left, tbl[i].left);
      chk($sformatf("vec%0d_block_state", i), block_state, exp_map);
    end

    // Clear every brick of level 0
    do_load(0, 104);
    base = clear_cnt;
    lc   = 1'b0;
    for (int r = 2; r <= 9; r++) begin
      for (int c = 0; c < 13; c++) begin
        do_hit(10'(8 + 48 * c + (c * 3) % 48), 9'(8 + 16 * r + r), edges, v, lc);
        chk($sformatf("clear_r%0d_c%0d", r, c), {edges[7:0], v}, {8'(c + 2), 1'b1});
      end
    end
    chk("clear_on_final_ack", lc, 1'b1);
    chk("clear_pulse_count", clear_cnt - base, 1);
    chk("clear_blocks_left", blocks_left, 0);
    chk("clear_block_state", block_state, '0);

    // Load issued three cycles into DIV; hit at col 10, row 4 (idx 62)
    @(negedge clk);
    hit_req = 1'b1;
    hit_x   = 10'd493;
    hit_y   = 9'd75;
    acks    = 0;
    repeat (4) begin
      @(negedge clk);
      if (hit_ack) acks++;
    end
    load_level = 1'b1;
    level      = 2'd3;
    @(negedge clk);
    load_level = 1'b0;
    busy_n = 0;
    idle_n = 0;
    while (!hit_ack && (busy_n + idle_n) < 80) begin
      if (busy) busy_n++;
      else      idle_n++;
      @(negedge clk);
    end
    v       = hit_valid;
    hit_req = 1'b0;
    exp_map = layout_map(3);
    exp_map[62] = 1'b0;
    chk("interrupt_no_early_ack", acks, 0);
    chk("interrupt_ack_seen", hit_ack, 1'b1);
    chk("interrupt_busy_cycles", busy_n, 16);
    chk("interrupt_idle_to_ack", idle_n, 12);
    chk("interrupt_hit_valid", v, 1'b1);
    chk("interrupt_blocks_left", blocks_left, 87);
    chk("interrupt_block_state", block_state, exp_map);
    repeat (2) @(negedge clk);
    chk("interrupt_no_reaccept", {hit_ack, blocks_left}, {1'b0, 8'd87});

    checks = checks + mon_checks;
    errors = errors + mon_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
